ca_signal_synth: RTL and testbench
==================================

CA_SIGNAL_SYNTH -- requirements
Module: ca_signal_synth

Interface
REQ-001 SHALL have parameter CA_RATE_INC, default 20'd1021613, DDS phase increment for 1.023 MHz chipping from 16.8 MHz.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, width of the chip-rate DDS accumulator.
REQ-003 SHALL have parameter SAMPLES_PER_MS, default 16800, number of samples per code epoch.
REQ-004 SHALL have parameter MS_PER_BIT, default 20, number of code epochs per navigation data bit.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  single-cycle pulse; latches prn and start_shift and begins generation.
REQ-008 stop  input  1  single-cycle pulse; returns the block to IDLE.
REQ-009 prn  input  5  satellite select; value n selects PRN n+1.
REQ-010 start_shift  input  15  sample offset of the first emitted sample, 0..16799.
REQ-011 data_in  input  1  next navigation data bit.
REQ-012 data_valid  input  1  data_in is valid.
REQ-013 data_ready  output  1  the one-entry bit buffer is empty.
REQ-014 sample_valid  output  1  out is a valid sample this cycle.
REQ-015 out  output  1  C/A chip XOR current data bit.
REQ-016 code_out  output  1  unmodulated C/A chip.
REQ-017 code_shift  output  15  sample index within the epoch, 0..16799.
REQ-018 chip_idx  output  10  chip index within the epoch, 0..1022.
REQ-019 epoch  output  5  epoch index within the data bit, 0..19.
REQ-020 underrun  output  1  sticky flag: a data-bit boundary occurred with the buffer empty.

Function
REQ-021 The block SHALL implement the states IDLE, SEEK and RUN.
REQ-022 IDLE SHALL go to SEEK on start.
REQ-023 SEEK SHALL go to RUN when the internal code_shift equals start_shift.
REQ-024 Any state SHALL go to IDLE on stop; stop SHALL take priority over start.
REQ-025 start SHALL be ignored in SEEK and RUN.
REQ-026 start_shift values above 16799 SHALL be clamped to 0.
REQ-027 Entering SEEK SHALL zero code_shift, the DDS accumulator, chip_idx and epoch, and SHALL load the LFSR with all ones.
REQ-028 SEEK SHALL advance the generator one sample per cycle with sample_valid=0 and out=0.
REQ-029 A start accepted in cycle t SHALL produce the first sample_valid in cycle t+1+start_shift.
REQ-030 RUN SHALL emit one sample per cycle with sample_valid=1.
REQ-031 In RUN and SEEK, the accumulator SHALL be updated as acc <= acc + CA_RATE_INC modulo 2^ACC_WIDTH on each sample.
REQ-032 A carry out of the accumulator SHALL advance chip_idx and the LFSR for the next sample.
REQ-033 Sample k SHALL therefore carry chip floor(k*CA_RATE_INC/2^24).
REQ-034 On the code_shift wrap 16799->0, the block SHALL force acc=0, chip_idx=0 and LFSR=all ones, giving exact epoch realignment.
REQ-035 On the code_shift wrap, epoch SHALL increment, wrapping 19->0.
REQ-036 On RUN entry and on every epoch wrap 19->0, the block SHALL load the current data bit from the buffer, empty the buffer, and raise data_ready.
REQ-037 If the buffer is empty at a data-bit load, the block SHALL repeat the previous bit (0 after reset) and set underrun.
REQ-038 A data_valid && data_ready handshake SHALL fill the buffer; data_ready SHALL drop the next cycle.
REQ-039 A handshake in the same cycle as a buffer load SHALL be held for the following bit.
REQ-040 Outputs SHALL be registered; out and code_out SHALL correspond to the same cycle's code_shift and chip_idx.
REQ-041 underrun SHALL be cleared only by reset or by start.

Reset
REQ-042 On reset=0, the block SHALL force state=IDLE, sample_valid=0, out=0, code_out=0, code_shift=0, chip_idx=0, epoch=0, underrun=0, data_ready=1, buffer empty and current data bit 0.
REQ-043 Reset mid-SEEK or mid-RUN SHALL abort generation within one cycle, and no partial samples SHALL follow.

Structure
REQ-044 Package gps_synth_pkg SHALL hold CA_RATE_INC, SAMPLES_PER_MS, MS_PER_BIT, CHIPS_PER_MS=1023, the state encoding and the G2 tap-pair table indexed by prn.
REQ-045 Sub-module ca_lfsr SHALL implement G1/G2 with load-all-ones, advance enable and a per-PRN tap select.

Verification
REQ-046 prn=0, start_shift=0, start: code_out over the first 10 chips SHALL be 1,1,0,0,1,0,0,0,0,0, and chip_idx SHALL first reach 1 at code_shift=17.
REQ-047 Free run for 1 ms: the last sample SHALL have code_shift=16799 and chip_idx=1022, and the next sample SHALL have code_shift=0, chip_idx=0 and epoch=1.
REQ-048 start_shift=5000: first sample_valid SHALL occur 5001 cycles after start with code_shift=5000, and its code_out SHALL match a start_shift=0 run at sample 5000.
REQ-049 Feed data bits 1,0 promptly: out SHALL equal ~code_out for epochs 0..19 and code_out for epochs 20..39, with underrun=0.
REQ-050 Withhold data after the first bit: at epoch 19->0, underrun SHALL be 1 and the previous bit SHALL be repeated.
REQ-051 Reset=0 at code_shift=8000 in RUN: the next cycle SHALL show sample_valid=0, all counters 0 and data_ready=1; a stop/start collision SHALL leave the block in IDLE.

Source files
------------

// File: rtl/gps_synth_pkg.sv
// Shared constants, FSM encoding and the per-PRN
// G2 phase-select tap table for the C/A synthesizer.
package gps_synth_pkg;

  localparam logic [19:0] CA_RATE_INC = 20'd1021613;
  localparam int SAMPLES_PER_MS = 16800;
  localparam int MS_PER_BIT = 20;
  localparam int CHIPS_PER_MS = 1023;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;

  // {tap_a, tap_b} into G2 stages 1..10, PRN 1..32
  localparam logic [7:0] G2_TAPS [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59,
    8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56,
    8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47,
    8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A,
    8'h16, 8'h27, 8'h38, 8'h49
  };

endpackage

// File: rtl/ca_lfsr.sv
// G1/G2 Gold-code generator; o_chip is the chip
// for the current register state.
module ca_lfsr
  import gps_synth_pkg::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic [4:0] i_prn,
  output logic       o_chip
);

  logic [10:1] r_g1;
  logic [10:1] r_g2;
  logic [7:0]  w_taps;
  logic [15:0] w_g2x;
  logic        w_fb1;
  logic        w_fb2;

  assign w_taps = G2_TAPS[i_prn];
  assign w_g2x = {5'b0, r_g2, 1'b0};
  assign o_chip = r_g1[10]
                ^ w_g2x[w_taps[7:4]]
                ^ w_g2x[w_taps[3:0]];

  assign w_fb1 = r_g1[3] ^ r_g1[10];
  assign w_fb2 = r_g2[2] ^ r_g2[3] ^ r_g2[6]
               ^ r_g2[8] ^ r_g2[9] ^ r_g2[10];

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_load) begin
      r_g1 <= '1;
      r_g2 <= '1;
    end else if (i_adv) begin
      r_g1 <= {r_g1[9:1], w_fb1};
      r_g2 <= {r_g2[9:1], w_fb2};
    end
  end

endmodule

// File: rtl/ca_signal_synth.sv
// GPS C/A baseband synthesizer: DDS chip timing,
// epoch alignment and nav-bit modulation.
module ca_signal_synth #(
  parameter logic [19:0] CA_RATE_INC = 20'd1021613,
  parameter int ACC_WIDTH = 24,
  parameter int SAMPLES_PER_MS = 16800,
  parameter int MS_PER_BIT = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  prn,
  input  logic [14:0] start_shift,
  input  logic        data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        sample_valid,
  output logic        out,
  output logic        code_out,
  output logic [14:0] code_shift,
  output logic [9:0]  chip_idx,
  output logic [4:0]  epoch,
  output logic        underrun
);

  import gps_synth_pkg::*;

  localparam logic [14:0] CS_LAST =
    15'(SAMPLES_PER_MS - 1);
  localparam logic [4:0] EP_LAST =
    5'(MS_PER_BIT - 1);
  localparam logic [9:0] CHIP_LAST =
    10'(CHIPS_PER_MS - 1);

  logic [1:0]           r_state;
  logic [4:0]           r_prn;
  logic [14:0]          r_shift;
  logic [14:0]          r_gcs;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [9:0]           r_gchip;
  logic [4:0]           r_gep;
  logic                 r_buf;
  logic                 r_full;
  logic                 r_bit;

  logic [ACC_WIDTH:0] w_sum;
  logic        w_carry;
  logic        w_cs_last;
  logic        w_go;
  logic        w_gen;
  logic        w_match;
  logic        w_load;
  logic        w_valid;
  logic        w_hs;
  logic        w_newbit;
  logic        w_bit;
  logic        w_chip;
  logic [14:0] w_shift;

  assign w_sum = {1'b0, r_acc}
               + (ACC_WIDTH + 1)'(CA_RATE_INC);
  assign w_carry = w_sum[ACC_WIDTH];
  assign w_cs_last = (r_gcs == CS_LAST);

  assign w_go = start && !stop
             && (r_state == ST_IDLE);
  assign w_gen = !stop
              && ((r_state == ST_SEEK)
              || (r_state == ST_RUN));
  assign w_match = (r_state == ST_SEEK)
                && (r_gcs == r_shift);
  assign w_valid = w_gen
                && ((r_state == ST_RUN) || w_match);

  // Bit loads on RUN entry and at each data-bit boundary
  assign w_load = w_gen && (w_match
               || ((r_state == ST_RUN)
               && (r_gcs == '0) && (r_gep == '0)));

  assign w_hs = data_valid && !r_full;
  assign w_newbit = r_full ? r_buf : r_bit;
  assign w_bit = w_load ? w_newbit : r_bit;
  assign data_ready = !r_full;

  assign w_shift = (start_shift > CS_LAST)
                 ? '0 : start_shift;

  ca_lfsr u_lfsr (
    .clk     (clk),
    .i_rst_n (reset),
    .i_load  (w_go || (w_gen && w_cs_last)),
    .i_adv   (w_gen && !w_cs_last && w_carry),
    .i_prn   (r_prn),
    .o_chip  (w_chip)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_prn        <= '0;
      r_shift      <= '0;
      r_gcs        <= '0;
      r_acc        <= '0;
      r_gchip      <= '0;
      r_gep        <= '0;
      r_buf        <= 1'b0;
      r_full       <= 1'b0;
      r_bit        <= 1'b0;
      sample_valid <= 1'b0;
      out          <= 1'b0;
      code_out     <= 1'b0;
      code_shift   <= '0;
      chip_idx     <= '0;
      epoch        <= '0;
      underrun     <= 1'b0;
    end else begin
      if (stop)
        r_state <= ST_IDLE;
      else if (w_go)
        r_state <= ST_SEEK;
      else if (w_match)
        r_state <= ST_RUN;

      if (w_go) begin
        r_prn    <= prn;
        r_shift  <= w_shift;
        r_gcs    <= '0;
        r_acc    <= '0;
        r_gchip  <= '0;
        r_gep    <= '0;
        underrun <= 1'b0;
      end else if (w_gen) begin
        if (w_cs_last) begin
          r_gcs   <= '0;
          r_acc   <= '0;
          r_gchip <= '0;
          r_gep   <= (r_gep == EP_LAST)
                   ? '0 : r_gep + 5'd1;
        end else begin
          r_gcs <= r_gcs + 15'd1;
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (w_carry && r_gchip != CHIP_LAST)
            r_gchip <= r_gchip + 10'd1;
        end
      end

      sample_valid <= w_valid;
      code_out     <= w_valid && w_chip;
      out          <= w_valid && (w_chip ^ w_bit);
      if (w_gen) begin
        code_shift <= r_gcs;
        chip_idx   <= r_gchip;
        epoch      <= r_gep;
      end

      // A handshake coinciding with a load refills for the next bit
      if (w_load) begin
        r_bit  <= w_newbit;
        r_full <= w_hs;
        if (w_hs)
          r_buf <= data_in;
        if (!r_full)
          underrun <= 1'b1;
      end else if (w_hs) begin
        r_full <= 1'b1;
        r_buf  <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_ca_signal_synth.sv
// Directed bench for ca_signal_synth, using two
// epochs per data bit to keep run length short.
module tb_ca_signal_synth;

  localparam longint INC = 1021613;
  localparam int SPM = 16800;
  localparam int BITLEN = 2 * SPM;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [4:0]  prn = '0;
  logic [14:0] start_shift = '0;
  logic        data_in = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        sample_valid;
  logic        out;
  logic        code_out;
  logic [14:0] code_shift;
  logic [9:0]  chip_idx;
  logic [4:0]  epoch;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ca_signal_synth #(.MS_PER_BIT(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .prn          (prn),
    .start_shift  (start_shift),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .sample_valid (sample_valid),
    .out          (out),
    .code_out     (code_out),
    .code_shift   (code_shift),
    .chip_idx     (chip_idx),
    .epoch        (epoch),
    .underrun     (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, want);
    end
  endtask

  task automatic get_chips(output logic [9:0] bits);
    int c;
    c = 0;
    bits = '0;
    for (int k = 0; k < 200 && c < 10; k++) begin
      if (chip_idx == 10'(c)) begin
        bits[9 - c] = code_out;
        c++;
      end
      tick();
    end
  endtask

  int n;
  int s;
  int c;
  int first1;
  longint ec;
  logic eb;
  logic rec5000;
  logic [9:0] chips;
  int bad_val, bad_cs, bad_chip, bad_ep;
  int bad_mod, bad_und;

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_ready", 32'(data_ready), 1);
    chk("rst_under", 32'(underrun), 0);
    chk("rst_out", 32'({out, code_out}), 0);
    chk("rst_cs", 32'(code_shift), 0);
    chk("rst_chip", 32'(chip_idx), 0);
    chk("rst_ep", 32'(epoch), 0);
    reset = 1'b1;

    // Run A: bits 1,0 then withheld
    data_in = 1'b1;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("buf_full_ready", 32'(data_ready), 0);
    prn = 5'd0;
    start_shift = 15'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seek_valid", 32'(sample_valid), 0);
    tick();

    c = 0;
    first1 = -1;
    chips = '0;
    bad_val = 0; bad_cs = 0; bad_chip = 0;
    bad_ep = 0; bad_mod = 0; bad_und = 0;
    for (int k = 0; k <= 2 * BITLEN; k++) begin
      s = k % SPM;
      ec = (longint'(s) * INC) >> 24;
      eb = (k < BITLEN);
      if (sample_valid !== 1'b1) bad_val++;
      if (code_shift !== 15'(s)) bad_cs++;
      if (chip_idx !== 10'(ec)) bad_chip++;
      if (epoch !== 5'((k / SPM) % 2)) bad_ep++;
      if ((out ^ code_out) !== eb) bad_mod++;
      if (underrun !== (k >= 2 * BITLEN))
        bad_und++;
      if (k < SPM && c < 10 && chip_idx == 10'(c)) begin
        chips[9 - c] = code_out;
        c++;
      end
      if (first1 < 0 && chip_idx == 10'd1)
        first1 = s;
      if (k == 5000) rec5000 = code_out;
      if (k == 0) begin
        chk("k0_ready", 32'(data_ready), 1);
        chk("k0_cs", 32'(code_shift), 0);
      end
      if (k == 1)
        chk("k1_ready", 32'(data_ready), 0);
      if (k == SPM - 1) begin
        chk("last_cs", 32'(code_shift), SPM - 1);
        chk("last_chip", 32'(chip_idx), 1022);
      end
      if (k == SPM) begin
        chk("wrap_cs", 32'(code_shift), 0);
        chk("wrap_chip", 32'(chip_idx), 0);
        chk("wrap_ep", 32'(epoch), 1);
      end
      if (k == BITLEN) begin
        chk("bit2_ready", 32'(data_ready), 1);
        chk("bit2_under", 32'(underrun), 0);
      end
      if (k == 2 * BITLEN - 1)
        chk("pre_under", 32'(underrun), 0);
      if (k == 2 * BITLEN) begin
        chk("underrun", 32'(underrun), 1);
        chk("repeat_bit", 32'(out ^ code_out), 0);
      end
      data_valid = (k == 0);
      data_in = 1'b0;
      if (k < 2 * BITLEN) tick();
    end
    data_valid = 1'b0;
    chk("prn1_chips", 32'(chips), 32'h320);
    chk("chip1_at", 32'(first1), 17);
    chk("run_valid", 32'(bad_val), 0);
    chk("run_cs", 32'(bad_cs), 0);
    chk("run_chip", 32'(bad_chip), 0);
    chk("run_ep", 32'(bad_ep), 0);
    chk("run_mod", 32'(bad_mod), 0);
    chk("run_under", 32'(bad_und), 0);

    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", 32'(sample_valid), 0);

    // Run B: start_shift 5000, then reset mid-RUN
    data_in = 1'b1;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    start_shift = 15'd5000;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (sample_valid !== 1'b1 && n < 6000) begin
      tick();
      n++;
    end
    chk("shift_lat", 32'(n), 5001);
    chk("shift_cs", 32'(code_shift), 5000);
    chk("shift_code", 32'(code_out), 32'(rec5000));
    chk("shift_mod", 32'(out ^ code_out), 1);
    chk("start_clr_under", 32'(underrun), 0);
    repeat (3000) tick();
    chk("pre_rst_cs", 32'(code_shift), 8000);
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_cs", 32'(code_shift), 0);
    chk("mid_rst_chip", 32'(chip_idx), 0);
    chk("mid_rst_ep", 32'(epoch), 0);
    chk("mid_rst_ready", 32'(data_ready), 1);
    chk("mid_rst_out", 32'(out), 0);
    reset = 1'b1;
    tick();
    chk("post_rst_valid", 32'(sample_valid), 0);

    // stop wins over start
    start_shift = 15'd0;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    chk("collide_valid", 32'(sample_valid), 0);

    // clamped offset, PRN 2
    prn = 5'd1;
    start_shift = 15'd20000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("clamp_valid", 32'(sample_valid), 1);
    chk("clamp_cs", 32'(code_shift), 0);
    get_chips(chips);
    chk("prn2_chips", 32'(chips), 32'h390);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
